// File: rtl/ahb3lite_sram_slave_pkg.sv
// Shared AHB3-Lite types for the SRAM responder: transfer/size codes, response codes, FSM states, lane mask.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } slv_state_t;

  // Byte lanes touched by a transfer of the given size at the given low address bits.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      HSIZE_BYTE: lane_mask = 4'b0001 << addr_lo;
      HSIZE_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb3lite_sram_slave_if.sv
// AHB3-Lite slave-side bus bundle between interconnect/master and the SRAM responder.
// Latency: n/a (wiring only).
// Backpressure: HREADY (mux) / HREADYOUT (slave) carried through.
interface ahb3lite_sram_slave_if #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) ();
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic                  HMASTLOCK;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [HDATA_SIZE-1:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb3lite_sram_mem.sv
// Word RAM, one write port with per-byte enables and one registered read port.
// Latency: read data one cycle after raddr; write takes effect at the clock edge.
// Backpressure: none; accepts a read and a write every cycle.
module ahb3lite_sram_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 32
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);
  logic [DW-1:0] mem [DEPTH];

  // Byte-enabled write; contents are never cleared by reset
  always_ff @(posedge HCLK) begin
    if (we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Registered read port, output register cleared on reset
  always_ff @(posedge HCLK) begin
    if (HRESET) rdata <= '0;
    else        rdata <= mem[raddr];
  end
endmodule

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite SRAM responder: pipelined address/data phase, byte lanes per HSIZE, two-cycle ERROR on illegal beats.
// Latency: one data-phase cycle per legal beat, 1+WAIT_CYCLES with AHB_SLV_WAITSTATE_EN; ERROR takes two.
// Backpressure: HREADYOUT low during wait states and ERROR first cycle; beats accepted only with HREADY high.
module ahb3lite_sram_slave
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic HCLK,
  input  logic HRESET,
  ahb3lite_sram_slave_if.slave bus
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [HADDR_SIZE-1:0] ADDR_LIMIT = HADDR_SIZE'(MEM_DEPTH * 4);

  slv_state_t            state;
  logic                  hreadyout_r;
  logic                  hresp_r;
  logic                  dp_vld;
  logic                  dp_write;
  logic [AW-1:0]         dp_idx;
  logic [3:0]            dp_mask;
  logic                  fwd_vld;
  logic [3:0]            fwd_mask;
  logic [HDATA_SIZE-1:0] fwd_dat;
`ifdef AHB_SLV_WAITSTATE_EN
  logic [3:0]            wait_cnt;
`endif

  logic                  accept;
  logic                  illegal;
  logic [AW-1:0]         addr_idx;
  logic [AW-1:0]         raddr;
  logic                  mem_we;
  logic [HDATA_SIZE-1:0] mem_rdata;
  logic [HDATA_SIZE-1:0] merged;
  logic                  unused_sigs;

  assign accept   = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign addr_idx = bus.HADDR[AW+1:2];
  assign illegal  = (bus.HADDR >= ADDR_LIMIT)
                  || (bus.HSIZE > HSIZE_WORD)
                  || ((bus.HSIZE == HSIZE_HALF) && bus.HADDR[0])
                  || ((bus.HSIZE == HSIZE_WORD) && (bus.HADDR[1:0] != 2'b00));

  // Write lands at the edge ending the completion cycle; a reset in that cycle drops it.
  assign mem_we = dp_vld & dp_write & hreadyout_r & ~HRESET;
  // A new address phase reads ahead so data is ready for its completion cycle; waits re-read the held address.
  assign raddr  = accept ? addr_idx : dp_idx;

  assign unused_sigs = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0]};

  ahb3lite_sram_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW),
    .DW    (HDATA_SIZE)
  ) u_mem (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .we     (mem_we),
    .waddr  (dp_idx),
    .wdata  (bus.HWDATA),
    .be     (dp_mask),
    .raddr  (raddr),
    .rdata  (mem_rdata)
  );

  // Bus-phase FSM: registered HREADYOUT/HRESP and latched data-phase control
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state       <= ST_IDLE;
      hreadyout_r <= 1'b1;
      hresp_r     <= HRESP_OKAY;
      dp_vld      <= 1'b0;
      dp_write    <= 1'b0;
      dp_idx      <= '0;
      dp_mask     <= '0;
      fwd_vld     <= 1'b0;
      fwd_mask    <= '0;
      fwd_dat     <= '0;
`ifdef AHB_SLV_WAITSTATE_EN
      wait_cnt    <= '0;
`endif
    end else begin
      // A read address phase overlapping a write completion to the same word misses the RAM update
      fwd_vld  <= mem_we & accept & ~bus.HWRITE & (addr_idx == dp_idx);
      fwd_mask <= dp_mask;
      fwd_dat  <= bus.HWDATA;
      case (state)
        ST_IDLE, ST_ERR2: begin
          state       <= ST_IDLE;
          hreadyout_r <= 1'b1;
          hresp_r     <= HRESP_OKAY;
          dp_vld      <= 1'b0;
          if (accept) begin
            dp_write <= bus.HWRITE;
            dp_idx   <= addr_idx;
            dp_mask  <= lane_mask(bus.HSIZE, bus.HADDR[1:0]);
            if (illegal) begin
              state       <= ST_ERR1;
              hreadyout_r <= 1'b0;
              hresp_r     <= HRESP_ERROR;
            end else begin
              dp_vld <= 1'b1;
`ifdef AHB_SLV_WAITSTATE_EN
              if (WAIT_CYCLES != 0) begin
                state       <= ST_WAIT;
                hreadyout_r <= 1'b0;
                wait_cnt    <= 4'(WAIT_CYCLES);
              end
`endif
            end
          end
        end
`ifdef AHB_SLV_WAITSTATE_EN
        ST_WAIT: begin
          if (wait_cnt == 4'd1) begin
            state       <= ST_IDLE;
            hreadyout_r <= 1'b1;
          end
          wait_cnt <= wait_cnt - 4'd1;
        end
`endif
        ST_ERR1: begin
          state       <= ST_ERR2;
          hreadyout_r <= 1'b1;
          hresp_r     <= HRESP_ERROR;
        end
        default: begin
          state       <= ST_IDLE;
          hreadyout_r <= 1'b1;
          hresp_r     <= HRESP_OKAY;
          dp_vld      <= 1'b0;
        end
      endcase
    end
  end

  // Overlay forwarded write bytes on the RAM word
  always_comb begin
    merged = mem_rdata;
    for (int b = 0; b < 4; b++) begin
      if (fwd_vld && fwd_mask[b]) merged[b*8 +: 8] = fwd_dat[b*8 +: 8];
    end
  end

  assign bus.HREADYOUT = hreadyout_r;
  assign bus.HRESP     = hresp_r;
  assign bus.HRDATA    = (dp_vld & ~dp_write) ? merged : '0;
endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench for the AHB3-Lite SRAM responder with a queue-based scoreboard and a bus monitor.
// Latency expectations: zero-wait beats, or 3 waits when AHB_SLV_WAITSTATE_EN is defined; ERROR = 1 wait + 1 cycle.
// Backpressure: HREADY is looped back from HREADYOUT as a single-slave mux would.
module tb_ahb3lite_sram_slave;
  import ahb3lite_pkg::*;

  localparam int MEM_DEPTH = 1024;
`ifdef AHB_SLV_WAITSTATE_EN
  localparam int EXP_WAITS = 3;
`else
  localparam int EXP_WAITS = 0;
`endif

  typedef struct {
    logic        is_read;
    logic [31:0] rdata;
    logic        resp;
    int          waits;
    string       name;
  } exp_t;

  logic  HCLK = 1'b0;
  logic  HRESET = 1'b1;
  exp_t  sb[$];
  int    total = 0;
  int    bad = 0;
  logic  pend = 1'b0;
  int    wcnt = 0;
  logic  err1 = 1'b0;

  always #5 HCLK = ~HCLK;

  ahb3lite_sram_slave_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb3lite_sram_slave #(
    .HADDR_SIZE  (32),
    .HDATA_SIZE  (32),
    .MEM_DEPTH   (MEM_DEPTH),
    .WAIT_CYCLES (3)
  ) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: tracks accepted beats from the bus, pops the scoreboard on each completion
  always @(negedge HCLK) begin
    exp_t e;
    if (HRESET) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (!bus.HREADYOUT) begin
          wcnt++;
          if (bus.HRESP) err1 = 1'b1;
        end else begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_completion: got completion expected none");
          end else begin
            e = sb.pop_front();
            chk({e.name, "_resp"}, 32'(bus.HRESP), 32'(e.resp));
            chk({e.name, "_waits"}, 32'(wcnt), 32'(e.waits));
            chk({e.name, "_err1"}, 32'(err1), 32'(e.resp));
            if (e.is_read && !e.resp) chk({e.name, "_rdata"}, bus.HRDATA, e.rdata);
          end
          pend = 1'b0;
        end
      end
      if (bus.HSEL && bus.HREADY && bus.HTRANS[1]) begin
        pend = 1'b1;
        wcnt = 0;
        err1 = 1'b0;
      end
    end
  end

  task automatic go_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = HTRANS_IDLE;
  endtask

  // Present one NONSEQ address phase, wait for acceptance, then drive its write data
  task automatic beat(input string nm, input logic [31:0] a, input logic w, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err, input bit push);
    int g = 0;
    bus.HSEL   = 1'b1;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HADDR  = a;
    bus.HWRITE = w;
    bus.HSIZE  = sz;
    if (push) sb.push_back('{is_read: !w, rdata: exp_rd, resp: exp_err,
                             waits: (exp_err ? 1 : EXP_WAITS), name: nm});
    @(negedge HCLK);
    while (!bus.HREADYOUT && g < 64) begin
      @(negedge HCLK);
      g++;
    end
    if (g >= 64) begin
      total++;
      bad++;
      $display("FAIL %s_accept_timeout: got HREADYOUT=0 expected 1 within 64 cycles", nm);
    end
    @(posedge HCLK);
    #1;
    bus.HWDATA = wd;
  endtask

  task automatic drain();
    int g = 0;
    go_idle();
    while ((sb.size() != 0 || pend) && g < 100) begin
      @(posedge HCLK);
      #1;
      g++;
    end
    if (g >= 100) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", sb.size());
    end
  endtask

  initial begin
    bus.HADDR     = '0;
    bus.HWRITE    = 1'b0;
    bus.HSIZE     = HSIZE_WORD;
    bus.HBURST    = 3'b000;
    bus.HPROT     = 4'b0011;
    bus.HMASTLOCK = 1'b0;
    bus.HWDATA    = '0;
    go_idle();
    HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("rst_hresp", 32'(bus.HRESP), 32'd0);
    chk("rst_hrdata", bus.HRDATA, 32'h0);
    @(posedge HCLK);
    #1;

    // Back-to-back pipelined traffic with same-word read-after-write forwarding
    beat("w0",   32'h0000, 1'b1, HSIZE_WORD, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1);
    beat("r0",   32'h0000, 1'b0, HSIZE_WORD, 32'h0,        32'hA5A5A5A5, 1'b0, 1'b1);
    beat("w4",   32'h0004, 1'b1, HSIZE_WORD, 32'h12345678, 32'h0, 1'b0, 1'b1);
    beat("r4a",  32'h0004, 1'b0, HSIZE_WORD, 32'h0,        32'h12345678, 1'b0, 1'b1);
    beat("wb5",  32'h0005, 1'b1, HSIZE_BYTE, 32'hAAAA99AA, 32'h0, 1'b0, 1'b1);
    beat("r4b",  32'h0004, 1'b0, HSIZE_WORD, 32'h0,        32'h12349978, 1'b0, 1'b1);
    beat("wh6",  32'h0006, 1'b1, HSIZE_HALF, 32'hBEEF5555, 32'h0, 1'b0, 1'b1);
    beat("r4c",  32'h0004, 1'b0, HSIZE_WORD, 32'h0,        32'hBEEF9978, 1'b0, 1'b1);
    // Illegal beats: out of range, misaligned word/half, oversize
    beat("e_oor",  32'h1000, 1'b0, HSIZE_WORD, 32'h0,        32'h0, 1'b1, 1'b1);
    beat("e_mis",  32'h0002, 1'b1, HSIZE_WORD, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
    beat("e_half", 32'h0001, 1'b1, HSIZE_HALF, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
    beat("e_size", 32'h0000, 1'b0, 3'b011,     32'h0,        32'h0, 1'b1, 1'b1);
    beat("r0u",  32'h0000, 1'b0, HSIZE_WORD, 32'h0,        32'hA5A5A5A5, 1'b0, 1'b1);
    beat("wb3",  32'h0003, 1'b1, HSIZE_BYTE, 32'h77000000, 32'h0, 1'b0, 1'b1);
    drain();
    // Reads with no overlapping write, straight from the RAM
    beat("r0v",  32'h0000, 1'b0, HSIZE_WORD, 32'h0,        32'h77A5A5A5, 1'b0, 1'b1);
    beat("r4d",  32'h0004, 1'b0, HSIZE_WORD, 32'h0,        32'hBEEF9978, 1'b0, 1'b1);
    // Last valid word
    beat("wtop", 32'h0FFC, 1'b1, HSIZE_WORD, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
    drain();
    beat("rtop", 32'h0FFC, 1'b0, HSIZE_WORD, 32'h0,        32'hCAFEF00D, 1'b0, 1'b1);
    beat("w8",   32'h0008, 1'b1, HSIZE_WORD, 32'h11223344, 32'h0, 1'b0, 1'b1);
    drain();

    // Reset during the data phase of a write drops it
    beat("w8rst", 32'h0008, 1'b1, HSIZE_WORD, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    HRESET = 1'b1;
    go_idle();
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("midrst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("midrst_hresp", 32'(bus.HRESP), 32'd0);
    chk("midrst_hrdata", bus.HRDATA, 32'h0);
    @(posedge HCLK);
    #1;
    beat("r8",   32'h0008, 1'b0, HSIZE_WORD, 32'h0,        32'h11223344, 1'b0, 1'b1);
    drain();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end
endmodule
